// File: rtl/state_handler_pkg.sv
// rtl/state_handler_pkg.sv - shared lane constants, tone table and state type for the rhythm game core
package state_handler_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_BITS = 12;
  localparam int SOUND_W   = 20;
  localparam int TIMER_W   = 25;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  localparam logic [SOUND_W-1:0] TONE0     = 20'd95602;
  localparam logic [SOUND_W-1:0] TONE1     = 20'd75873;
  localparam logic [SOUND_W-1:0] TONE2     = 20'd63776;
  localparam logic [SOUND_W-1:0] TONE3     = 20'd47755;
  localparam logic [SOUND_W-1:0] MISS_TONE = 20'd454545;

  localparam logic [SOUND_W-1:0] LANE_TONE [NUM_LANES] = '{TONE0, TONE1, TONE2, TONE3};

endpackage

// File: rtl/state_handler_button_edge.sv
// rtl/state_handler_button_edge.sv - registered rising-edge detector so a held button counts once
module button_edge
  import state_handler_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NUM_LANES-1:0] data_i,
  output logic [NUM_LANES-1:0] rise_o
);

  logic [NUM_LANES-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      prev_q <= '0;
    end else begin
      prev_q <= data_i;
    end
  end

  assign rise_o = data_i & ~prev_q;

endmodule

// File: rtl/state_handler.sv
// rtl/state_handler.sv - judges lane presses against the hit row and drives clear pulses and tones
module state_handler
  import state_handler_pkg::*;
#(
  parameter int                 LANE_BITS   = state_handler_pkg::LANE_BITS,
  parameter int                 HIT_ROW     = 0,
  parameter int                 NOTE_CYCLES = 25000000,
  parameter logic [SOUND_W-1:0] TONE0       = state_handler_pkg::TONE0,
  parameter logic [SOUND_W-1:0] TONE1       = state_handler_pkg::TONE1,
  parameter logic [SOUND_W-1:0] TONE2       = state_handler_pkg::TONE2,
  parameter logic [SOUND_W-1:0] TONE3       = state_handler_pkg::TONE3,
  parameter logic [SOUND_W-1:0] MISS_TONE   = state_handler_pkg::MISS_TONE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_LANES-1:0]           button_press,
  input  logic [NUM_LANES*LANE_BITS-1:0] square_locations,
  output logic [NUM_LANES-1:0]           column,
  output logic [SOUND_W-1:0]             sound
);

  localparam logic [SOUND_W-1:0] TONES [NUM_LANES] = '{TONE0, TONE1, TONE2, TONE3};
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(NOTE_CYCLES - 1);

  logic [NUM_LANES-1:0] press;
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] miss;
  logic [SOUND_W-1:0]   hit_tone;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [SOUND_W-1:0]   sound_q, sound_d;
  logic [NUM_LANES-1:0] column_q, column_d;

  button_edge u_button_edge (
    .clk_i  (clk),
    .rstn_i (rst),
    .data_i (button_press),
    .rise_o (press)
  );

  // Descending scan so the lowest-indexed hit lane picks the tone.
  always_comb begin
    hit      = '0;
    miss     = '0;
    hit_tone = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      hit[i]  = press[i] &  square_locations[LANE_BITS*i + HIT_ROW];
      miss[i] = press[i] & ~square_locations[LANE_BITS*i + HIT_ROW];
      if (hit[i]) begin
        hit_tone = TONES[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    sound_d  = sound_q;
    column_d = hit;

    case (state_q)
      PLAY: begin
        if (timer_q == '0) begin
          state_d = IDLE;
          sound_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        sound_d = '0;
      end
    endcase

    // A new press overrides the countdown in the same cycle, so tones chain gaplessly.
    if (hit != '0) begin
      state_d = PLAY;
      sound_d = hit_tone;
      timer_d = TIMER_LOAD;
    end else if (miss != '0) begin
      state_d = PLAY;
      sound_d = MISS_TONE;
      timer_d = TIMER_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      sound_q  <= '0;
      column_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      sound_q  <= sound_d;
      column_q <= column_d;
    end
  end

  assign column = column_q;
  assign sound  = sound_q;

endmodule

// File: tb/tb_state_handler.sv
// tb/tb_state_handler.sv - scoreboard bench for state_handler with an 8-cycle note length
module tb_state_handler;

  localparam logic [19:0] T0   = 20'd95602;
  localparam logic [19:0] T1   = 20'd75873;
  localparam logic [19:0] T2   = 20'd63776;
  localparam logic [19:0] MISS = 20'd454545;
  localparam logic [19:0] SIL  = 20'd0;

  logic        clk;
  logic        rst;
  logic [3:0]  button_press;
  logic [47:0] square_locations;
  logic [3:0]  column;
  logic [19:0] sound;

  logic [3:0]  exp_col [$];
  logic [19:0] exp_snd [$];
  int          vectors;
  int          errors;

  state_handler #(
    .NOTE_CYCLES (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .button_press     (button_press),
    .square_locations (square_locations),
    .column           (column),
    .sound            (sound)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0]  ec;
    logic [19:0] es;
    for (int s = 0; s < 4; s++) begin
      rst              = (s < 3) ? 1'b0 : 1'b1;
      button_press     = (s < 3) ? 4'($urandom) : 4'b0000;
      square_locations = {16'($urandom), 32'($urandom)};
      exp_col.push_back(4'b0000);
      exp_snd.push_back(SIL);
      @(negedge clk);
      ec = exp_col.pop_front();
      es = exp_snd.pop_front();
      vectors++;
      if (column !== ec || sound !== es) begin
        errors++;
        $display("FAIL reset step %0d: column=%b sound=%0d, want column=%b sound=%0d", s, column, sound, ec, es);
      end
    end
  endtask

  task automatic test_single_hit();
    logic [3:0]  ec;
    logic [19:0] es;
    for (int s = 0; s < 10; s++) begin
      square_locations = 48'h1;
      button_press     = (s == 0) ? 4'b0001 : 4'b0000;
      exp_col.push_back((s == 0) ? 4'b0001 : 4'b0000);
      exp_snd.push_back((s < 8) ? T0 : SIL);
      @(negedge clk);
      ec = exp_col.pop_front();
      es = exp_snd.pop_front();
      vectors++;
      if (column !== ec || sound !== es) begin
        errors++;
        $display("FAIL single_hit step %0d: column=%b sound=%0d, want column=%b sound=%0d", s, column, sound, ec, es);
      end
    end
  endtask

  task automatic test_miss();
    logic [3:0]  ec;
    logic [19:0] es;
    for (int s = 0; s < 10; s++) begin
      square_locations = 48'h0;
      button_press     = (s == 0) ? 4'b0100 : 4'b0000;
      exp_col.push_back(4'b0000);
      exp_snd.push_back((s < 8) ? MISS : SIL);
      @(negedge clk);
      ec = exp_col.pop_front();
      es = exp_snd.pop_front();
      vectors++;
      if (column !== ec || sound !== es) begin
        errors++;
        $display("FAIL miss step %0d: column=%b sound=%0d, want column=%b sound=%0d", s, column, sound, ec, es);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0]  ec;
    logic [19:0] es;
    for (int s = 0; s < 9; s++) begin
      square_locations = (48'h1 << 12) | (48'h1 << 36);
      button_press     = (s == 0) ? 4'b1011 : 4'b0000;
      exp_col.push_back((s == 0) ? 4'b1010 : 4'b0000);
      exp_snd.push_back((s < 8) ? T1 : SIL);
      @(negedge clk);
      ec = exp_col.pop_front();
      es = exp_snd.pop_front();
      vectors++;
      if (column !== ec || sound !== es) begin
        errors++;
        $display("FAIL simultaneous step %0d: column=%b sound=%0d, want column=%b sound=%0d", s, column, sound, ec, es);
      end
    end
  endtask

  task automatic test_ignored_rows();
    logic [3:0]  ec;
    logic [19:0] es;
    for (int s = 0; s < 11; s++) begin
      square_locations = 48'hFFE_FFE_FFE_FFE;
      button_press     = (s == 2) ? 4'b1111 : 4'b0000;
      exp_col.push_back(4'b0000);
      exp_snd.push_back((s >= 2 && s < 10) ? MISS : SIL);
      @(negedge clk);
      ec = exp_col.pop_front();
      es = exp_snd.pop_front();
      vectors++;
      if (column !== ec || sound !== es) begin
        errors++;
        $display("FAIL ignored_rows step %0d: column=%b sound=%0d, want column=%b sound=%0d", s, column, sound, ec, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ec;
    logic [19:0] es;
    for (int s = 0; s < 12; s++) begin
      square_locations = 48'h1 | (48'h1 << 24);
      if (s < 3)      button_press = 4'b0001;
      else if (s < 5) button_press = 4'b0101;
      else            button_press = 4'b0000;
      if (s == 0)      exp_col.push_back(4'b0001);
      else if (s == 3) exp_col.push_back(4'b0100);
      else             exp_col.push_back(4'b0000);
      if (s < 3)       exp_snd.push_back(T0);
      else if (s < 11) exp_snd.push_back(T2);
      else             exp_snd.push_back(SIL);
      @(negedge clk);
      ec = exp_col.pop_front();
      es = exp_snd.pop_front();
      vectors++;
      if (column !== ec || sound !== es) begin
        errors++;
        $display("FAIL back_to_back step %0d: column=%b sound=%0d, want column=%b sound=%0d", s, column, sound, ec, es);
      end
    end
  endtask

  task automatic test_reset_mid_tone();
    logic [3:0]  ec;
    logic [19:0] es;
    for (int s = 0; s < 11; s++) begin
      rst              = (s == 2) ? 1'b0 : 1'b1;
      square_locations = 48'h1 | (48'h1 << 12);
      if (s == 0)      button_press = 4'b0001;
      else if (s == 2) button_press = 4'b0010;
      else             button_press = 4'b0000;
      exp_col.push_back((s == 0) ? 4'b0001 : 4'b0000);
      exp_snd.push_back((s < 2) ? T0 : SIL);
      @(negedge clk);
      ec = exp_col.pop_front();
      es = exp_snd.pop_front();
      vectors++;
      if (column !== ec || sound !== es) begin
        errors++;
        $display("FAIL reset_mid_tone step %0d: column=%b sound=%0d, want column=%b sound=%0d", s, column, sound, ec, es);
      end
    end
  endtask

  initial begin
    vectors          = 0;
    errors           = 0;
    rst              = 1'b0;
    button_press     = 4'b0000;
    square_locations = 48'h0;
    test_reset();
    test_single_hit();
    test_miss();
    test_simultaneous();
    test_ignored_rows();
    test_back_to_back();
    test_reset_mid_tone();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/state_handler.md
Name: state_handler

Overview:
- Game-logic core of the 4-lane rhythm game; sits between the debounced button inputs, the falling-square generator and the audio tone generator.
- Each button press is judged against the occupancy of that lane's hit row.
- A hit produces a one-cycle clear pulse on `column` for the square generator and a lane tone on `sound`; a press on an empty hit row produces the miss tone.

Parameters:
- LANE_BITS, 12, rows per lane in `square_locations`; 4 lanes × 12 = 48 bits.
- HIT_ROW, 0, row index inside each lane that forms the hit zone.
- NOTE_CYCLES, 25000000, clock cycles a tone is held on `sound`; tests override it to 8.
- TONE0, 95602, half-period count for lane 0 (C5 at 100 MHz).
- TONE1, 75873, half-period count for lane 1 (E5).
- TONE2, 63776, half-period count for lane 2 (G5).
- TONE3, 47755, half-period count for lane 3 (C6).
- MISS_TONE, 454545, half-period count for the miss buzz (110 Hz).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
- button_press  in  4  per-lane button level/pulse, bit i = lane i.
- square_locations  in  48  occupancy map: lane i is bits [12i+11:12i], bit 12i+HIT_ROW is lane i's hit row.
- column  out  4  one-hot (or multi-hot) lane-clear pulse to the square generator, 1 cycle wide.
- sound  out  20  tone half-period to the audio generator; 0 = silence.

Behaviour:
- Reset (rst=0 at posedge): column=0, sound=0, timer=0, state=IDLE, button history register=0.
- Press detection:
  - press[i] = button_press[i] & ~prev[i]; prev is registered every cycle.
  - A held button counts once; a one-cycle pulse counts once.
- Judgement in the cycle press≠0, using `square_locations` sampled in that same cycle:
  - hit[i] = press[i] & square_locations[12i+HIT_ROW].
  - miss[i] = press[i] & ~square_locations[12i+HIT_ROW].
- Outputs are registered, with 1-cycle latency from the sampling edge:
  - column <= hit, asserted for exactly one cycle, then 0.
  - If hit≠0: sound <= TONEk, where k is the lowest-indexed hit lane; state <= PLAY.
  - Else if miss≠0: sound <= MISS_TONE; state <= PLAY.
  - Hits take priority over misses when pressed simultaneously. `column` still reports every hit lane.
  - In both cases timer <= NOTE_CYCLES-1.
- State machine:
  - IDLE: sound=0.
  - PLAY: timer decrements each cycle. When timer==0, next cycle state=IDLE and sound=0. `sound` is held for exactly NOTE_CYCLES cycles.
  - A new press during PLAY restarts the timer and replaces `sound`, with no gap cycle.
- `square_locations` bits other than the hit rows are ignored.
- A press on a lane whose hit row is set in a cycle with no press has no effect; there is no auto-miss on passing squares.
- Reset mid-PLAY silences on the next edge. A press in the reset cycle is discarded, and prev is cleared.
- Timer is 25 bits wide, sized for NOTE_CYCLES.

Decomposition:
- Package `state_handler_pkg`:
  - NUM_LANES=4, LANE_BITS, SOUND_W=20.
  - state enum {IDLE, PLAY}.
  - tone constants TONE0-3, MISS_TONE, as a 4-entry lane tone array.
- One sub-module `button_edge`: 4-bit registered rising-edge detector with synchronous active-low reset.
- Judgement, priority encode, tone select and timer stay in the top module.

Test Plan (NOTE_CYCLES=8):
- Reset: hold rst=0 for 3 cycles with random inputs → column=0, sound=0 throughout and one cycle after release.
- Single hit:
  - Stimulus: square_locations=48'h1, button_press=4'b0001 pulsed 1 cycle.
  - Next cycle: column=4'b0001 for 1 cycle, sound=95602 for exactly 8 cycles, then 0.
- Miss:
  - Stimulus: square_locations=0, button_press=4'b0100.
  - Required: column stays 0; sound=454545 for 8 cycles, then 0.
- Simultaneous:
  - Stimulus: lanes 1 and 3 hit rows set (bits 12 and 36), button_press=4'b1011.
  - Required: column=4'b1010, sound=75873 (lane 1, hit beats lane-0 miss).
- Held button / retrigger:
  - Stimulus: hold button_press=4'b0001 for 5 cycles with bit 0 set.
  - Required: exactly one column pulse and one 8-cycle tone.
  - Then press lane 2 (bit 24 set) at cycle 4 of the tone → sound switches to 63776 immediately and lasts 8 more cycles.
- Reset mid-tone: assert rst=0 during PLAY → sound=0 on the next edge; no further tone.
